// File: rtl/multicycle_control.sv
// Sequencing controller for the multi-cycle RV32I core.
// Each instruction is walked through FETCH/DECODE/EXEC/MEM/WB. The controller
// drives every datapath enable and mux select from the current state and the
// opcode. It also supports variable-latency memory, all six conditional
// branches, and lui/jal/jalr. Illegal opcodes and memory timeouts lock the
// controller in TRAP until reset.
//
// Memory handshake: in FETCH and MEM the strobe (mem_read or mem_write) is
// held high for as long as the state lasts. The access completes in the cycle
// where mem_ready is high, and the controller leaves the state on that edge.
// With MEM_WAIT=0, mem_ready is ignored and every access completes in its
// first cycle.
module multicycle_control #(
  parameter bit MEM_WAIT    = 1'b1,
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state
);

  // State codes, visible on the state port for debug.
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  // RV32I major opcodes handled by this core.
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  // The timeout only exists when waits are honoured and a limit is set.
  localparam bit              TIMEOUT_EN  = MEM_WAIT && (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TIMEOUT_CNT = TO_W'(MEM_TIMEOUT);

  logic [2:0]      state_q;
  logic [2:0]      state_next;
  logic [TO_W-1:0] count_q;
  logic            illegal_q;
  logic            bus_err_q;

  // Opcode classes.
  logic is_r, is_i, is_load, is_store, is_br;
  logic is_auipc, is_lui, is_jal, is_jalr;
  logic op_known;
  logic decode_ok;
  logic taken;

  // Memory completion and timeout qualifiers.
  logic in_mem_state;
  logic mem_done;
  logic timeout_hit;
  logic timeout_trap;

  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_br    = (opcode == OP_BR);
  assign is_auipc = (opcode == OP_AUIPC);
  assign is_lui   = (opcode == OP_LUI);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);

  assign op_known = is_r | is_i | is_load | is_store | is_br |
                    is_auipc | is_lui | is_jal | is_jalr;

  // func3 values 010 and 011 are not branch encodings.
  assign decode_ok = op_known && !(is_br && (func3[2:1] == 2'b01));

  assign in_mem_state = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign mem_done     = MEM_WAIT ? mem_ready : 1'b1;

  // mem_ready in the limit cycle wins over the timeout.
  assign timeout_hit  = TIMEOUT_EN && (count_q == TIMEOUT_CNT) && !mem_ready;
  assign timeout_trap = in_mem_state && !mem_done && timeout_hit;

  // Branch condition from func3 and the ALU comparison flags.
  always_comb begin
    taken = 1'b0;
    case (func3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  // State register; reset restarts at FETCH and abandons any instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_next;
    end
  end

  // Next-state selection.
  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_done) begin
          state_next = ST_DECODE;
        end else if (timeout_hit) begin
          state_next = ST_TRAP;
        end
      end
      ST_DECODE: begin
        state_next = decode_ok ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        if (is_br) begin
          state_next = ST_FETCH;
        end else if (is_load || is_store) begin
          state_next = ST_MEM;
        end else begin
          state_next = ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_done) begin
          state_next = is_store ? ST_FETCH : ST_WB;
        end else if (timeout_hit) begin
          state_next = ST_TRAP;
        end
      end
      ST_WB: begin
        state_next = ST_FETCH;
      end
      ST_TRAP: begin
        state_next = ST_TRAP;
      end
      default: begin
        state_next = ST_TRAP;
      end
    endcase
  end

  // Wait counter (per memory access) and the sticky trap flags.
  // The counter saturates, so it cannot wrap when the timeout is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      if ((state_next != state_q) &&
          ((state_next == ST_FETCH) || (state_next == ST_MEM))) begin
        count_q <= '0;
      end else if (in_mem_state && !mem_done && (count_q != '1)) begin
        count_q <= count_q + TO_W'(1);
      end
      if (state_next == ST_TRAP) begin
        illegal_q <= 1'b1;
      end
      if (timeout_trap) begin
        bus_err_q <= 1'b1;
      end
    end
  end

  // Datapath controls, decoded from state and opcode.
  // While rst is high, everything is held at zero.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = 2'b00;
    instr_done = 1'b0;
    if (!rst) begin
      if ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB)) begin
        if (is_r) begin
          alu_op = 2'b10;
        end else if (is_i) begin
          alu_src_b = 1'b1;
          alu_op    = 2'b11;
        end else if (is_load || is_store || is_jalr) begin
          alu_src_b = 1'b1;
        end else if (is_auipc) begin
          alu_src_a = 1'b1;
          alu_src_b = 1'b1;
        end else if (is_br) begin
          alu_op = 2'b01;
        end
      end
      case (state_q)
        ST_FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_done;
        end
        ST_EXEC: begin
          if (is_br) begin
            pc_write   = 1'b1;
            pc_src     = taken ? 2'b01 : 2'b00;
            instr_done = 1'b1;
          end
        end
        ST_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = is_load;
          mem_write = is_store;
          if (is_store && mem_done) begin
            pc_write   = 1'b1;
            instr_done = 1'b1;
          end
        end
        ST_WB: begin
          reg_write  = 1'b1;
          pc_write   = 1'b1;
          instr_done = 1'b1;
          if (is_load) begin
            mem_to_reg = 2'b01;
          end else if (is_jal || is_jalr) begin
            mem_to_reg = 2'b10;
          end else if (is_lui) begin
            mem_to_reg = 2'b11;
          end
          if (is_jal) begin
            pc_src = 2'b01;
          end else if (is_jalr) begin
            pc_src = 2'b10;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign state   = state_q;

endmodule
